// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster generator: pixel divider, h/v counters, tick pulses and
// sync/blank outputs delayed to line up with the renderers' registered colour.
module vga_sync_gen #(
  parameter int   CLK_DIV    = 4,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       pix_tick,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [9:0]       r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  logic             r_pix_tick, r_line_tick, r_frame_tick, w_tick_nxt;
  logic             r_hsync, r_vsync;
  logic [3:0]       r_r, r_g, r_b;
  logic [2:0]       w_raw, w_dly;

  // Ticks are registered from the next-state divider so they line up with it.
  always_comb begin
    w_div_nxt  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_tick_nxt = (w_div_nxt == DIV_LAST);
    w_h_nxt    = r_h_cnt;
    w_v_nxt    = r_v_cnt;
    if (r_pix_tick) begin
      if (r_h_cnt == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
      end else begin
        w_h_nxt = r_h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div        <= '0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_pix_tick   <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_pix_tick   <= w_tick_nxt;
      r_line_tick  <= w_tick_nxt && (w_h_nxt == H_LAST);
      r_frame_tick <= w_tick_nxt && (w_h_nxt == H_LAST) && (w_v_nxt == V_LAST);
    end
  end

  assign w_raw = {(r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END),
                  (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END),
                  (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT)};

  // Stage p1..pN: {hs,vs,de} delay matching the renderer latency.
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign w_dly = w_raw;
    end else begin : g_dly
      logic [2:0] r_dly_p [PIPE_DELAY];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) r_dly_p[i] <= '0;
        end else begin
          r_dly_p[0] <= w_raw;
          for (int i = 1; i < PIPE_DELAY; i++) r_dly_p[i] <= r_dly_p[i-1];
        end
      end
      assign w_dly = r_dly_p[PIPE_DELAY-1];
    end
  endgenerate

  // Output stage: polarity and blanking applied in the last register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else begin
      r_hsync <= w_dly[2] ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_dly[1] ? SYNC_POL : ~SYNC_POL;
      r_r     <= w_dly[0] ? r_in : 4'h0;
      r_g     <= w_dly[0] ? g_in : 4'h0;
      r_b     <= w_dly[0] ? b_in : 4'h0;
    end
  end

  assign h_cnt      = r_h_cnt;
  assign v_cnt      = r_v_cnt;
  assign pix_tick   = r_pix_tick;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign r          = r_r;
  assign g          = r_g;
  assign b          = r_b;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations checked every cycle against an
// arithmetic raster model, plus scenario checks on periods, sync widths and reset.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] r_in = '0, g_in = '0, b_in = '0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        pt, lt, ft, hs, vs;
    logic [11:0] rgb;
  } obs_t;

  logic [9:0] d_h, d_v, f_h, f_v, s_h, s_v;
  logic       d_pt, d_lt, d_ft, d_hs, d_vs, f_pt, f_lt, f_ft, f_hs, f_vs;
  logic       s_pt, s_lt, s_ft, s_hs, s_vs;
  logic [3:0] d_r, d_g, d_b, f_r, f_g, f_b, s_r, s_g, s_b;
  obs_t a_def, a_fast, a_small;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .h_cnt(d_h), .v_cnt(d_v), .pix_tick(d_pt), .line_tick(d_lt), .frame_tick(d_ft),
    .hsync(d_hs), .vsync(d_vs), .r(d_r), .g(d_g), .b(d_b));

  vga_sync_gen #(.CLK_DIV(1), .PIPE_DELAY(0)) u_fast (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .h_cnt(f_h), .v_cnt(f_v), .pix_tick(f_pt), .line_tick(f_lt), .frame_tick(f_ft),
    .hsync(f_hs), .vsync(f_vs), .r(f_r), .g(f_g), .b(f_b));

  vga_sync_gen #(.CLK_DIV(2), .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(3),
                 .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
                 .SYNC_POL(1'b1), .PIPE_DELAY(3)) u_small (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .h_cnt(s_h), .v_cnt(s_v), .pix_tick(s_pt), .line_tick(s_lt), .frame_tick(s_ft),
    .hsync(s_hs), .vsync(s_vs), .r(s_r), .g(s_g), .b(s_b));

  assign a_def   = {d_h, d_v, d_pt, d_lt, d_ft, d_hs, d_vs, d_r, d_g, d_b};
  assign a_fast  = {f_h, f_v, f_pt, f_lt, f_ft, f_hs, f_vs, f_r, f_g, f_b};
  assign a_small = {s_h, s_v, s_pt, s_lt, s_ft, s_hs, s_vs, s_r, s_g, s_b};

  int n_vec = 0;
  int n_err = 0;

  // t = clk cycles since the last edge that saw reset; hist[k] = colour driven in cycle k.
  int          t = 0;
  logic [11:0] hist[$];
  always @(posedge clk) begin
    if (reset) begin
      t = 0;
      hist.delete();
    end else begin
      hist.push_back({r_in, g_in, b_in});
      t = t + 1;
    end
  end

  // Pixels completed by the start of cycle tt (first pixel ends in cycle CLK_DIV-1, never cycle 0).
  function automatic int pix_count(int tt, int D);
    if (tt <= 0) return 0;
    return (D == 1) ? tt - 1 : tt / D;
  endfunction

  function automatic obs_t model(int tt, int D, int HA, int HFP, int HS, int HB,
                                 int VA, int VFP, int VS, int VB, int PD, logic pol);
    int   ht, vt, n, src, sn, sh, sv;
    obs_t o;
    ht = HA + HFP + HS + HB;
    vt = VA + VFP + VS + VB;
    n  = pix_count(tt, D);
    o.h  = 10'(n % ht);
    o.v  = 10'((n / ht) % vt);
    o.pt = (tt >= 1) && (tt % D == D - 1);
    o.lt = o.pt && (n % ht == ht - 1);
    o.ft = o.lt && ((n / ht) % vt == vt - 1);
    o.hs = ~pol;
    o.vs = ~pol;
    o.rgb = '0;
    src = tt - 1 - PD;
    if (src >= 0) begin
      sn = pix_count(src, D);
      sh = sn % ht;
      sv = (sn / ht) % vt;
      if (sh >= HA + HFP && sh < HA + HFP + HS) o.hs = pol;
      if (sv >= VA + VFP && sv < VA + VFP + VS) o.vs = pol;
      if (sh < HA && sv < VA) o.rgb = hist[tt-1];
    end
    return o;
  endfunction

  function automatic obs_t m_def(int tt);
    return model(tt, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0);
  endfunction
  function automatic obs_t m_fast(int tt);
    return model(tt, 1, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0);
  endfunction
  function automatic obs_t m_small(int tt);
    return model(tt, 2, 10, 3, 4, 3, 6, 2, 2, 2, 3, 1'b1);
  endfunction

  task automatic drive_rand();
    {r_in, g_in, b_in} = 12'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_rand();
      n_vec += 4;
      if (a_def !== m_def(t)) begin n_err++; $display("FAIL reset_def got %h want %h", a_def, m_def(t)); end
      if (a_fast !== m_fast(t)) begin n_err++; $display("FAIL reset_fast got %h want %h", a_fast, m_fast(t)); end
      if (a_small !== m_small(t)) begin n_err++; $display("FAIL reset_small got %h want %h", a_small, m_small(t)); end
      if (a_small !== {10'd0, 10'd0, 5'b00000, 12'd0}) begin
        n_err++; $display("FAIL reset_small_const got %h want all-zero", a_small);
      end
    end
  endtask

  task automatic test_pix_tick();
    int first_d = -1, first_f = -1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_vec += 3;
      if (a_def !== m_def(t)) begin n_err++; $display("FAIL pix_def t=%0d got %h want %h", t, a_def, m_def(t)); end
      if (a_fast !== m_fast(t)) begin n_err++; $display("FAIL pix_fast t=%0d got %h want %h", t, a_fast, m_fast(t)); end
      if (a_small !== m_small(t)) begin n_err++; $display("FAIL pix_small t=%0d got %h want %h", t, a_small, m_small(t)); end
      if (d_pt && first_d < 0) first_d = t;
      if (f_pt && first_f < 0) first_f = t;
      if (t == 4) begin
        n_vec++;
        if (d_h !== 10'd1) begin n_err++; $display("FAIL pix_h_after_first got %0d want 1", d_h); end
      end
      drive_rand();
    end
    n_vec += 2;
    if (first_d !== 3) begin n_err++; $display("FAIL pix_first_def got %0d want 3", first_d); end
    if (first_f !== 1) begin n_err++; $display("FAIL pix_first_fast got %0d want 1", first_f); end
  endtask

  task automatic test_line_and_frame();
    obs_t pd, pf, ps;
    int d_lt = -1, f_lt = -1, s_ft = -1, d656 = -1, dfall = -1, f656 = -1, ffall = -1;
    int s8 = -1, srise = -1, n_dl = 0, wraps = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    pd = a_def; pf = a_fast; ps = a_small;
    for (int i = 0; i < 6500; i++) begin
      @(negedge clk);
      n_vec += 3;
      if (a_def !== m_def(t)) begin n_err++; $display("FAIL run_def t=%0d got %h want %h", t, a_def, m_def(t)); end
      if (a_fast !== m_fast(t)) begin n_err++; $display("FAIL run_fast t=%0d got %h want %h", t, a_fast, m_fast(t)); end
      if (a_small !== m_small(t)) begin n_err++; $display("FAIL run_small t=%0d got %h want %h", t, a_small, m_small(t)); end
      if (a_def.lt) begin
        if (d_lt >= 0) begin n_vec++; if (t - d_lt !== 3200) begin n_err++; $display("FAIL line_period_def got %0d want 3200", t - d_lt); end end
        d_lt = t; n_dl++;
      end
      if (a_fast.lt) begin
        if (f_lt >= 0) begin n_vec++; if (t - f_lt !== 800) begin n_err++; $display("FAIL line_period_fast got %0d want 800", t - f_lt); end end
        f_lt = t;
      end
      if (a_small.ft) begin
        if (s_ft >= 0) begin n_vec++; if (t - s_ft !== 480) begin n_err++; $display("FAIL frame_period_small got %0d want 480", t - s_ft); end end
        s_ft = t;
      end
      if (a_def.h == 10'd656 && pd.h != 10'd656) d656 = t;
      if (!a_def.hs && pd.hs) begin
        dfall = t; n_vec++;
        if (dfall - d656 !== 2) begin n_err++; $display("FAIL hs_start_def got %0d want 2", dfall - d656); end
      end
      if (a_def.hs && !pd.hs && dfall >= 0) begin
        n_vec++; if (t - dfall !== 384) begin n_err++; $display("FAIL hs_width_def got %0d want 384", t - dfall); end
      end
      if (a_fast.h == 10'd656) f656 = t;
      if (!a_fast.hs && pf.hs) begin
        ffall = t; n_vec++;
        if (ffall - f656 !== 1) begin n_err++; $display("FAIL hs_start_fast got %0d want 1", ffall - f656); end
      end
      if (a_fast.hs && !pf.hs && ffall >= 0) begin
        n_vec++; if (t - ffall !== 96) begin n_err++; $display("FAIL hs_width_fast got %0d want 96", t - ffall); end
      end
      if (a_small.v == 10'd8 && ps.v != 10'd8) s8 = t;
      if (a_small.vs && !ps.vs) begin
        srise = t; n_vec++;
        if (srise - s8 !== 4) begin n_err++; $display("FAIL vs_start_small got %0d want 4", srise - s8); end
      end
      if (!a_small.vs && ps.vs && srise >= 0) begin
        n_vec++; if (t - srise !== 80) begin n_err++; $display("FAIL vs_width_small got %0d want 80", t - srise); end
      end
      if (ps.v == 10'd11 && a_small.v == 10'd0) wraps++;
      pd = a_def; pf = a_fast; ps = a_small;
      drive_rand();
    end
    n_vec += 2;
    if (n_dl < 2) begin n_err++; $display("FAIL line_ticks_seen got %0d want >=2", n_dl); end
    if (wraps < 2) begin n_err++; $display("FAIL v_wraps_small got %0d want >=2", wraps); end
  endtask

  task automatic test_blank();
    int s_ft = -1, s_cnt = 0, d_lt = -1, d_cnt = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    {r_in, g_in, b_in} = 12'hFFF;
    for (int i = 0; i < 6450; i++) begin
      @(negedge clk);
      n_vec += 3;
      if (a_def !== m_def(t)) begin n_err++; $display("FAIL blank_def t=%0d got %h want %h", t, a_def, m_def(t)); end
      if (a_fast !== m_fast(t)) begin n_err++; $display("FAIL blank_fast t=%0d got %h want %h", t, a_fast, m_fast(t)); end
      if (a_small !== m_small(t)) begin n_err++; $display("FAIL blank_small t=%0d got %h want %h", t, a_small, m_small(t)); end
      if (s_ft >= 0 && a_small.rgb == 12'hFFF) s_cnt++;
      if (a_small.ft) begin
        if (s_ft >= 0) begin n_vec++; if (s_cnt !== 120) begin n_err++; $display("FAIL lit_small_frame got %0d want 120", s_cnt); end end
        s_ft = t; s_cnt = 0;
      end
      if (d_lt >= 0 && a_def.rgb == 12'hFFF) d_cnt++;
      if (a_def.lt) begin
        if (d_lt >= 0) begin n_vec++; if (d_cnt !== 2560) begin n_err++; $display("FAIL lit_def_line got %0d want 2560", d_cnt); end end
        d_lt = t; d_cnt = 0;
      end
    end
  endtask

  task automatic test_mid_reset();
    bit hit = 0;
    int first_tick = -1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      drive_rand();
      if (d_h == 10'd300) hit = 1;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL midrst_reach got h=%0d want 300", d_h); end
    reset = 1'b1;
    @(negedge clk);
    n_vec += 2;
    if (a_def !== {10'd0, 10'd0, 5'b00011, 12'd0}) begin
      n_err++; $display("FAIL midrst_def got %h want %h", a_def, {10'd0, 10'd0, 5'b00011, 12'd0});
    end
    if (a_small !== m_small(t)) begin n_err++; $display("FAIL midrst_small got %h want %h", a_small, m_small(t)); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++;
      if (a_def !== m_def(t)) begin n_err++; $display("FAIL midrst_run t=%0d got %h want %h", t, a_def, m_def(t)); end
      if (d_pt && first_tick < 0) first_tick = t;
      drive_rand();
    end
    n_vec++;
    if (first_tick !== 3) begin n_err++; $display("FAIL midrst_first_tick got %0d want 3", first_tick); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_vec += 3;
      if (a_def !== m_def(t)) begin n_err++; $display("FAIL b2b_def t=%0d got %h want %h", t, a_def, m_def(t)); end
      if (a_fast !== m_fast(t)) begin n_err++; $display("FAIL b2b_fast t=%0d got %h want %h", t, a_fast, m_fast(t)); end
      if (a_small !== m_small(t)) begin n_err++; $display("FAIL b2b_small t=%0d got %h want %h", t, a_small, m_small(t)); end
      reset = ($urandom_range(0, 24) == 0);
      drive_rand();
    end
  endtask

  initial begin
    test_reset();
    test_pix_tick();
    test_line_and_frame();
    test_blank();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
